// File: rtl/fp_sample_streamer_pkg.sv
// Shared IEEE-754 single-precision field layout, Q1.15 limits and FP class
// definitions for the sample streamer.
package fp_sample_streamer_pkg;

  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;
  localparam int EXP_BIAS = 127;
  localparam int SIG_W    = MANT_W + 1;
  localparam int FP_W     = 1 + EXP_W + MANT_W;
  localparam int Q15_W    = 16;

  localparam logic signed [Q15_W-1:0] Q15_MAX = 16'sh7FFF;
  localparam logic signed [Q15_W-1:0] Q15_MIN = 16'sh8000;

  // Exponent thresholds: E >= 0 saturates, E < -15 underflows to zero,
  // and the right-shift of the significand is (8 - E) = (BIAS + 8) - exp.
  localparam logic [EXP_W-1:0] EXP_UNITY     = EXP_W'(EXP_BIAS);
  localparam logic [EXP_W-1:0] EXP_MIN_Q15   = EXP_W'(EXP_BIAS - 15);
  localparam logic [EXP_W-1:0] EXP_SHIFT_REF = EXP_W'(EXP_BIAS + 8);

  localparam logic [FP_W-1:0] FP_NEG_ONE = 32'hBF80_0000;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORMAL,
    FP_INF,
    FP_NAN
  } fp_class_e;

  function automatic fp_class_e fp_classify(input logic [EXP_W-1:0]  exp_f,
                                            input logic [MANT_W-1:0] mant);
    if (exp_f == '0) return FP_ZERO;
    if (exp_f == '1) return (mant == '0) ? FP_INF : FP_NAN;
    return FP_NORMAL;
  endfunction

endpackage

// File: rtl/fp_sample_streamer_fifo.sv
// Sample FIFO: DEPTH x DATA_W, head word visible combinationally, flush clears
// occupancy; a push at full is accepted only when a pop frees a slot that cycle.
module sample_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fp_sample_streamer.sv
// Converts IEEE-754 single terms to Q1.15 DAC samples through a 2-stage
// pipeline, buffers them in a FIFO and releases one per rate-counter tick.
module fp_sample_streamer
  import fp_sample_streamer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [FP_W-1:0]   term,
  input  logic              term_valid,
  input  logic              seq_done,
  input  logic [15:0]       rate_div,
  output logic [Q15_W-1:0]  dac_code,
  output logic              dac_strobe,
  output logic              fifo_full,
  output logic              overflow_err,
  output logic              sat_flag,
  output logic              stream_done
);

  function automatic logic signed [Q15_W-1:0] q15_limit(input logic neg);
    return neg ? Q15_MIN : Q15_MAX;
  endfunction

  // Truncated magnitude, clamped if anything spills past 15 fraction bits,
  // then negated for negative inputs.
  function automatic logic signed [Q15_W-1:0] q15_from_sig(input logic [SIG_W-1:0] shifted,
                                                           input logic             neg);
    logic signed [Q15_W-1:0] mag;
    if (|shifted[SIG_W-1:Q15_W-1]) return q15_limit(neg);
    mag = {1'b0, shifted[Q15_W-2:0]};
    return neg ? -mag : mag;
  endfunction

  logic                    sign_c;
  logic [EXP_W-1:0]        exp_c;
  logic [MANT_W-1:0]       mant_c;
  logic [EXP_W-1:0]        shift_c;

  logic                    vld_p0;
  logic                    sign_p0;
  fp_class_e               cls_p0;
  logic                    ovr_p0;
  logic                    unf_p0;
  logic                    neg_one_p0;
  logic [EXP_W-1:0]        shift_p0;
  logic [SIG_W-1:0]        sig_p0;

  logic [SIG_W-1:0]        shifted_c;
  logic signed [Q15_W-1:0] code_c;
  logic                    sat_c;

  logic                    vld_p1;
  logic signed [Q15_W-1:0] code_p1;

  logic [15:0]             rate_cnt;
  logic                    tick;
  logic                    pop;
  logic                    push;
  logic                    seq_latch;

  logic [Q15_W-1:0]        fifo_rd_data;
  logic                    fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_count;

  assign sign_c  = term[FP_W-1];
  assign exp_c   = term[FP_W-2:MANT_W];
  assign mant_c  = term[MANT_W-1:0];
  assign shift_c = EXP_SHIFT_REF - exp_c;

  // Stage 0: unpack and classify
  always_ff @(posedge clk) begin
    if (term_valid) begin
      sign_p0    <= sign_c;
      cls_p0     <= fp_classify(exp_c, mant_c);
      ovr_p0     <= (exp_c >= EXP_UNITY);
      unf_p0     <= (exp_c < EXP_MIN_Q15);
      neg_one_p0 <= (term == FP_NEG_ONE);
      shift_p0   <= shift_c;
      sig_p0     <= {1'b1, mant_c};
    end
  end

  always_comb begin
    shifted_c = sig_p0 >> shift_p0;
    code_c    = '0;
    sat_c     = 1'b0;
    case (cls_p0)
      FP_ZERO: begin
        code_c = '0;
      end
      FP_NAN: begin
        code_c = '0;
        sat_c  = 1'b1;
      end
      FP_INF: begin
        code_c = q15_limit(sign_p0);
        sat_c  = 1'b1;
      end
      FP_NORMAL: begin
        if (ovr_p0) begin
          code_c = q15_limit(sign_p0);
          sat_c  = !neg_one_p0;
        end else if (unf_p0) begin
          code_c = '0;
        end else begin
          code_c = q15_from_sig(shifted_c, sign_p0);
        end
      end
      default: begin
        code_c = '0;
      end
    endcase
  end

  // Stage 1: shift, saturate, negate
  always_ff @(posedge clk) begin
    if (vld_p0) code_p1 <= code_c;
  end

  assign push = enable && vld_p1;
  assign tick = enable && (rate_cnt >= rate_div);
  assign pop  = tick && (fifo_count != '0);

  sample_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (Q15_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (!enable),
    .push    (push),
    .pop     (pop),
    .wr_data (code_p1),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Output stage and control: valids, rate counter, sticky flags, completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0       <= 1'b0;
      vld_p1       <= 1'b0;
      rate_cnt     <= '0;
      dac_code     <= '0;
      dac_strobe   <= 1'b0;
      overflow_err <= 1'b0;
      sat_flag     <= 1'b0;
      seq_latch    <= 1'b0;
      stream_done  <= 1'b0;
    end else if (!enable) begin
      vld_p0       <= 1'b0;
      vld_p1       <= 1'b0;
      rate_cnt     <= '0;
      dac_strobe   <= 1'b0;
      overflow_err <= 1'b0;
      sat_flag     <= 1'b0;
      seq_latch    <= 1'b0;
      stream_done  <= 1'b0;
    end else begin
      vld_p0     <= term_valid;
      vld_p1     <= vld_p0;
      rate_cnt   <= (rate_cnt >= rate_div) ? '0 : rate_cnt + 16'd1;
      dac_strobe <= pop;
      if (pop) dac_code <= fifo_rd_data;
      if (push && fifo_full && !pop) overflow_err <= 1'b1;
      if (vld_p0 && sat_c) sat_flag <= 1'b1;
      if (seq_done) seq_latch <= 1'b1;
      if (seq_latch && !vld_p0 && !vld_p1 && fifo_empty) stream_done <= 1'b1;
    end
  end

endmodule

// File: doc/fp_sample_streamer.md
FP_SAMPLE_STREAMER -- requirements
Module: fp_sample_streamer

Interface
REQ-001 Parameter: DEPTH, 8, sample FIFO depth (power of two, >=2).
REQ-002 clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-004 enable  in  1  stream enable; low = flush/idle.
REQ-005 term  in  32  IEEE-754 single term from the sequence generator.
REQ-006 term_valid  in  1  one-cycle qualifier for term.
REQ-007 seq_done  in  1  generator sequence-complete level.
REQ-008 rate_div  in  16  sample period minus one, in clk cycles.
REQ-009 dac_code  out  16  signed Q1.15 sample, held between strobes.
REQ-010 dac_strobe  out  1  one-cycle pulse; dac_code is new in that cycle.
REQ-011 fifo_full  out  1  FIFO occupancy == DEPTH.
REQ-012 overflow_err  out  1  sticky; a converted sample was dropped.
REQ-013 sat_flag  out  1  sticky; a sample was clamped or was NaN.
REQ-014 stream_done  out  1  all terms of the sequence have been output.

Function
REQ-015 Conversion SHALL be a 2-stage pipeline: stage 1 unpacks and classifies; stage 2 shifts, saturates and negates; the result is written to the FIFO 2 cycles after term_valid.
REQ-016 With E = exp-127: exp==0 (zero/denormal, incl. -0) -> 0; E+15<0 -> 0.
REQ-017 -15<=E<=-1 -> magnitude = {1,mant} >> (8-E), truncated toward zero, then negated if sign=1.
REQ-018 E>=0 or Inf: positive -> 0x7FFF; negative -> 0x8000; sat_flag set, except exactly -1.0 (0xBF800000), which maps to 0x8000 without setting sat_flag.
REQ-019 NaN (exp==255, mant!=0) -> 0x0000 and sets sat_flag.
REQ-020 Rate counter SHALL count 0..rate_div and wrap; a tick occurs in the cycle the count equals rate_div; rate_div=0 -> tick every cycle.
REQ-021 On a tick, if occupancy at the start of the cycle is >0: pop, register dac_code, and pulse dac_strobe next cycle; if empty: no strobe, dac_code held.
REQ-022 A push with the FIFO full and no pop in the same cycle SHALL drop the sample and set overflow_err; push and pop in the same cycle at full SHALL both succeed.
REQ-023 There is no same-cycle bypass: a sample written to an empty FIFO is poppable from the following cycle.
REQ-024 seq_done SHALL be latched while enable=1; stream_done SHALL assert once the latch is set, the pipeline is empty and the FIFO is empty, and stay high until enable falls.
REQ-025 enable=0 SHALL discard inputs, flush the pipeline and FIFO, hold the rate counter at 0, clear the seq_done latch, stream_done, overflow_err and sat_flag, and hold dac_code.

Reset
REQ-026 rst_n low SHALL asynchronously clear: dac_code=0, dac_strobe=0, fifo_full=0, overflow_err=0, sat_flag=0, stream_done=0, FIFO pointers and occupancy, pipeline valids, rate counter, and the seq_done latch.
REQ-027 Reset mid-stream SHALL discard all buffered samples; operation resumes from empty after release.

Structure
REQ-028 A shared package SHALL hold the IEEE-754 field widths and bias (8, 23, 127), the Q1.15 limits 0x7FFF/0x8000 and the FP class enum (ZERO, NORMAL, INF, NAN).
REQ-029 The FIFO SHALL be one sub-module, sample_fifo (DEPTH x 16, full/empty/count outputs); conversion and rate logic stay in the top level.

Verification
REQ-030 rate_div=0; 0x3F000000 then 0xBF000000 -> dac_code 0x4000 then 0xC000, strobes in order, sat_flag=0.
REQ-031 0x40000000 -> 0x7FFF with sat_flag=1; then, after enable toggle, 0xBF800000 -> 0x8000 with sat_flag=0; 0xFF800000 -> 0x8000 with sat_flag=1; 0x7FC00000 -> 0x0000 with sat_flag=1.
REQ-032 0x38000000 -> 0x0001; 0x37800000 -> 0x0000; 0x80000000 -> 0x0000.
REQ-033 rate_div=99; 10 back-to-back terms from cycle 0 -> 8 stored, fifo_full=1, overflow_err=1, then 8 strobes spaced 100 cycles.
REQ-034 rate_div=3; 5 terms, then seq_done=1 -> stream_done rises after the 5th strobe once FIFO and pipeline are empty; enable=0 -> stream_done=0.
REQ-035 rst_n pulsed low with 4 samples queued -> all outputs 0 immediately, no further strobes until new terms arrive.
